// File: rtl/hv_wdg_reg_scan.sv
// rtl/hv_wdg_reg_scan.sv - watchdog register scanner with CRC-8 check and ack timeout
//
// Purpose:
//   Walks the register window [i_scan_start_addr .. i_scan_end_addr] one read
//   at a time through the register access controller's watchdog-scan port,
//   recomputes CRC-8 (poly 0x07, init 0x00, MSB first, no reflection, no final
//   XOR) over {addr, data} and compares it with the stored CRC. CRC mismatches
//   and missing acknowledges are reported as sticky flags with the first error
//   address and a saturating error count.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_scan_en                 scan enable (level)
//   i_scan_start_addr         first address of the window
//   i_scan_end_addr           last address of the window
//   i_scan_intv               idle cycles before each read
//   i_err_clr                 clears sticky flags, error address and counter (pulse)
//   o_wdg_scan_rac_rd_req     read request, held until ack or timeout
//   o_wdg_scan_rac_addr       read address
//   i_rac_wdg_scan_ack        read acknowledge (one-cycle pulse)
//   i_rac_wdg_scan_data       read data, valid with ack
//   i_rac_wdg_scan_crc        stored CRC, valid with ack
//   o_scan_crc_err            sticky CRC mismatch flag
//   o_scan_tmo_err            sticky acknowledge-timeout flag
//   o_scan_err_addr           address of the first error since the last clear
//   o_scan_err_cnt            saturating error count
//   o_scan_done               one-cycle pulse per completed window pass

module hv_wdg_reg_scan #(
  parameter int REG_AW      = 7,
  parameter int REG_DW      = 8,
  parameter int REG_CRC_W   = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int INTV_W      = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_scan_en,
  input  logic [REG_AW-1:0]    i_scan_start_addr,
  input  logic [REG_AW-1:0]    i_scan_end_addr,
  input  logic [INTV_W-1:0]    i_scan_intv,
  input  logic                 i_err_clr,
  output logic                 o_wdg_scan_rac_rd_req,
  output logic [REG_AW-1:0]    o_wdg_scan_rac_addr,
  input  logic                 i_rac_wdg_scan_ack,
  input  logic [REG_DW-1:0]    i_rac_wdg_scan_data,
  input  logic [REG_CRC_W-1:0] i_rac_wdg_scan_crc,
  output logic                 o_scan_crc_err,
  output logic                 o_scan_tmo_err,
  output logic [REG_AW-1:0]    o_scan_err_addr,
  output logic [7:0]           o_scan_err_cnt,
  output logic                 o_scan_done
);

  localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
  localparam int MSG_W = REG_AW + REG_DW;
  localparam logic [REG_CRC_W-1:0] CRC_POLY = REG_CRC_W'(7);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_CHK
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [REG_AW-1:0]     r_addr;
  logic [INTV_W-1:0]     r_intv_cnt;
  logic [TCNT_W-1:0]     r_tcnt;
  logic [REG_DW-1:0]     r_data;
  logic [REG_CRC_W-1:0]  r_crc;
  logic                  r_rd_req;
  logic                  r_done;
  logic                  r_crc_err;
  logic                  r_tmo_err;
  logic [REG_AW-1:0]     r_err_addr;
  logic [7:0]            r_err_cnt;
  logic                  r_tmo_pend;
  logic [REG_AW-1:0]     r_tmo_addr;

  logic                  w_ack_hit;
  logic                  w_tmo_hit;
  logic [REG_CRC_W-1:0]  w_crc_calc;
  logic                  w_crc_bad;
  logic                  w_adv;
  logic                  w_wrap;
  logic [REG_AW-1:0]     w_addr_nxt;
  logic                  w_err_ev;
  logic [REG_AW-1:0]     w_ev_addr;
  logic                  w_any_err;

  // Bit-serial CRC, MSB of the message first.
  function automatic logic [REG_CRC_W-1:0] crc_calc(input logic [MSG_W-1:0] msg);
    logic [REG_CRC_W-1:0] c;
    c = '0;
    for (int i = MSG_W - 1; i >= 0; i--) begin
      c = {c[REG_CRC_W-2:0], 1'b0} ^ ((c[REG_CRC_W-1] ^ msg[i]) ? CRC_POLY : '0);
    end
    return c;
  endfunction

  // Ack takes priority over a timeout landing in the same cycle.
  assign w_ack_hit = (r_state == S_REQ) && i_rac_wdg_scan_ack;
  assign w_tmo_hit = (r_state == S_REQ) && !i_rac_wdg_scan_ack && (r_tcnt == TCNT_LAST);

  assign w_crc_calc = crc_calc({r_addr, r_data});
  assign w_crc_bad  = (r_state == S_CHK) && (w_crc_calc != r_crc);

  // Address advances after every finished read (checked or timed out).
  // An inverted window collapses to the start address and counts as a full pass.
  assign w_adv      = w_tmo_hit || (r_state == S_CHK);
  assign w_wrap     = (r_addr == i_scan_end_addr) || (i_scan_start_addr > i_scan_end_addr);
  assign w_addr_nxt = w_wrap ? i_scan_start_addr : (r_addr + REG_AW'(1));

  // A timeout is recorded one cycle after the request drops, from a captured
  // copy of the address. A timeout always passes through WAIT before the next
  // CHK, so the two error sources never collide.
  assign w_err_ev  = w_crc_bad || r_tmo_pend;
  assign w_ev_addr = w_crc_bad ? r_addr : r_tmo_addr;
  assign w_any_err = r_crc_err || r_tmo_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_scan_en) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_scan_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_intv_cnt == '0) begin
          w_state_nxt = S_REQ;
        end
      end
      // Enable is not looked at here: an issued request always runs to ack or timeout.
      S_REQ: begin
        if (w_ack_hit) begin
          w_state_nxt = S_CHK;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_CHK: begin
        w_state_nxt = S_WAIT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_intv_cnt <= '0;
      r_tcnt     <= '0;
      r_data     <= '0;
      r_crc      <= '0;
      r_rd_req   <= 1'b0;
      r_done     <= 1'b0;
      r_tmo_pend <= 1'b0;
      r_tmo_addr <= '0;
    end else begin
      r_rd_req   <= (w_state_nxt == S_REQ);
      r_done     <= w_adv && w_wrap;
      r_tmo_pend <= w_tmo_hit;
      if (w_tmo_hit) begin
        r_tmo_addr <= r_addr;
      end
      case (r_state)
        S_IDLE: begin
          if (i_scan_en) begin
            r_addr     <= i_scan_start_addr;
            r_intv_cnt <= i_scan_intv;
          end
        end
        S_WAIT: begin
          r_tcnt <= '0;
          if (i_scan_en && (r_intv_cnt != '0)) begin
            r_intv_cnt <= r_intv_cnt - INTV_W'(1);
          end
        end
        S_REQ: begin
          if (w_ack_hit) begin
            r_data <= i_rac_wdg_scan_data;
            r_crc  <= i_rac_wdg_scan_crc;
          end else if (w_tmo_hit) begin
            r_addr     <= w_addr_nxt;
            r_intv_cnt <= i_scan_intv;
          end else begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
          end
        end
        S_CHK: begin
          r_addr     <= w_addr_nxt;
          r_intv_cnt <= i_scan_intv;
        end
        default: begin
          r_tcnt <= '0;
        end
      endcase
    end
  end

  // Error bookkeeping. A new error beats a simultaneous clear: the clear wipes
  // the old history and the new error becomes the first one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc_err  <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end else if (w_err_ev) begin
      if (i_err_clr) begin
        r_crc_err  <= w_crc_bad;
        r_tmo_err  <= r_tmo_pend;
        r_err_addr <= w_ev_addr;
        r_err_cnt  <= 8'd1;
      end else begin
        r_crc_err <= r_crc_err | w_crc_bad;
        r_tmo_err <= r_tmo_err | r_tmo_pend;
        if (!w_any_err) begin
          r_err_addr <= w_ev_addr;
        end
        if (r_err_cnt != 8'hFF) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end
    end else if (i_err_clr) begin
      r_crc_err  <= 1'b0;
      r_tmo_err  <= 1'b0;
      r_err_addr <= '0;
      r_err_cnt  <= '0;
    end
  end

  assign o_wdg_scan_rac_rd_req = r_rd_req;
  assign o_wdg_scan_rac_addr   = r_addr;
  assign o_scan_crc_err        = r_crc_err;
  assign o_scan_tmo_err        = r_tmo_err;
  assign o_scan_err_addr       = r_err_addr;
  assign o_scan_err_cnt        = r_err_cnt;
  assign o_scan_done           = r_done;

endmodule

// File: tb/tb_hv_wdg_reg_scan.sv
// tb/tb_hv_wdg_reg_scan.sv - self-checking bench for hv_wdg_reg_scan

module tb_hv_wdg_reg_scan;

  typedef struct packed {
    logic       crc;
    logic       tmo;
    logic [6:0] eaddr;
    logic [7:0] cnt;
    logic       done;
  } res_t;

  typedef struct {
    int         ew;
    int         dly;
    logic [7:0] dat;
    logic       bad;
    res_t       e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [6:0]  sa;
  logic [6:0]  ea;
  logic [15:0] intv;
  logic        clr;
  logic        rd_req;
  logic [6:0]  raddr;
  logic        ack;
  logic [7:0]  adata;
  logic [7:0]  acrc;
  logic        crc_err;
  logic        tmo_err;
  logic [6:0]  err_addr;
  logic [7:0]  err_cnt;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] sb_addr[$];
  res_t       exp_q[$];
  vec_t       tbl[9];

  always #5 clk = ~clk;

  hv_wdg_reg_scan dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_scan_en             (en),
    .i_scan_start_addr     (sa),
    .i_scan_end_addr       (ea),
    .i_scan_intv           (intv),
    .i_err_clr             (clr),
    .o_wdg_scan_rac_rd_req (rd_req),
    .o_wdg_scan_rac_addr   (raddr),
    .i_rac_wdg_scan_ack    (ack),
    .i_rac_wdg_scan_data   (adata),
    .i_rac_wdg_scan_crc    (acrc),
    .o_scan_crc_err        (crc_err),
    .o_scan_tmo_err        (tmo_err),
    .o_scan_err_addr       (err_addr),
    .o_scan_err_cnt        (err_cnt),
    .o_scan_done           (done)
  );

  // Reference CRC as the remainder of msg * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [14:0] msg);
    logic [22:0] r;
    r = {msg, 8'h00};
    for (int i = 22; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic res_t mkres(input logic c, input logic t, input logic [6:0] a,
                                 input logic [7:0] n, input logic d);
    res_t r;
    r.crc = c; r.tmo = t; r.eaddr = a; r.cnt = n; r.done = d;
    return r;
  endfunction

  function automatic vec_t mkv(input int ew, input int dly, input logic [7:0] dat,
                               input logic bad, input res_t e);
    vec_t v;
    v.ew = ew; v.dly = dly; v.dat = dat; v.bad = bad; v.e = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or scoreboard empty at %0t", nm, $time);
  endtask

  task automatic wait_req(output int w, output bit seen);
    w = 0;
    seen = 1'b0;
    while (!seen && w < 300) begin
      @(negedge clk);
      w++;
      if (rd_req === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic ack_and_check(input logic [6:0] a, input int dly, input logic [7:0] dat,
                               input logic bad, input logic clr_chk, input res_t e);
    logic [7:0] c;
    res_t x;
    c = crc_ref({a, dat});
    if (bad) c = c ^ 8'h01;
    repeat (dly) @(posedge clk);
    #1;
    ack = 1'b1; adata = dat; acrc = c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    ack = 1'b0;
    if (clr_chk) clr = 1'b1;
    @(negedge clk);
    chk("rd_req_drop", rd_req, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      fail_now("exp_q_empty");
    end else begin
      x = exp_q.pop_front();
      chk("crc_err", crc_err, x.crc);
      chk("tmo_err", tmo_err, x.tmo);
      chk("err_addr", err_addr, x.eaddr);
      chk("err_cnt", err_cnt, x.cnt);
      chk("done", done, x.done);
    end
  endtask

  task automatic serve(input int ew, input int dly, input logic [7:0] dat, input logic bad,
                       input logic clr_chk, input res_t e);
    int w;
    bit seen;
    logic [6:0] a;
    wait_req(w, seen);
    if (!seen) begin
      fail_now("rd_req_wait");
      return;
    end
    if (ew > 0) chk("req_latency", w, ew);
    if (sb_addr.size() == 0) begin
      fail_now("sb_addr_empty");
      return;
    end
    a = sb_addr.pop_front();
    chk("rd_addr", raddr, a);
    ack_and_check(a, dly, dat, bad, clr_chk, e);
  endtask

  task automatic clear_errs();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("clr_crc_err", crc_err, 0);
    chk("clr_tmo_err", tmo_err, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_no_req", rd_req, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int hi;
    int anyreq;
    bit seen;
    logic [6:0] a;
    logic [7:0] n;

    tbl[0] = mkv(3, 3, 8'h00, 1'b0, mkres(0, 0, 7'h00, 8'd0, 0));
    tbl[1] = mkv(1, 3, 8'h5A, 1'b0, mkres(0, 0, 7'h00, 8'd0, 0));
    tbl[2] = mkv(1, 3, 8'hA5, 1'b0, mkres(0, 0, 7'h00, 8'd0, 1));
    tbl[3] = mkv(1, 3, 8'h00, 1'b0, mkres(0, 0, 7'h00, 8'd0, 0));
    tbl[4] = mkv(1, 2, 8'h3C, 1'b0, mkres(0, 0, 7'h00, 8'd0, 0));
    tbl[5] = mkv(1, 1, 8'hC3, 1'b0, mkres(0, 0, 7'h00, 8'd0, 1));
    tbl[6] = mkv(1, 3, 8'h00, 1'b1, mkres(1, 0, 7'h00, 8'd1, 0));
    tbl[7] = mkv(1, 3, 8'h77, 1'b1, mkres(1, 0, 7'h00, 8'd2, 0));
    tbl[8] = mkv(1, 3, 8'h81, 1'b0, mkres(1, 0, 7'h00, 8'd2, 1));

    rst = 1'b1; en = 1'b0; sa = '0; ea = '0; intv = '0; clr = 1'b0;
    ack = 1'b0; adata = '0; acrc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_addr", raddr, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_tmo_err", tmo_err, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Window 0..2, back-to-back reads, clean passes then CRC mismatches.
    sa = 7'h00; ea = 7'h02; intv = 16'd0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 3; k++) sb_addr.push_back(7'(k));
    end
    @(posedge clk);
    #1 en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      serve(tbl[i].ew, tbl[i].dly, tbl[i].dat, tbl[i].bad, 1'b0, tbl[i].e);
    end
    en = 1'b0;
    clear_errs();

    // Acknowledge timeout on address 3, then a normal read of address 4.
    sa = 7'h03; ea = 7'h04; intv = 16'd2;
    sb_addr.push_back(7'h03);
    @(posedge clk);
    #1 en = 1'b1;
    wait_req(w, seen);
    if (!seen) begin
      fail_now("tmo_rd_req_wait");
    end else begin
      chk("tmo_req_latency", w, 5);
      a = sb_addr.pop_front();
      chk("tmo_rd_addr", raddr, a);
      hi = 1;
      while (hi < 200) begin
        @(negedge clk);
        if (rd_req) hi++;
        else break;
      end
      chk("tmo_req_width", hi, 64);
      chk("tmo_flag_early", tmo_err, 0);
      @(negedge clk);
      chk("tmo_flag", tmo_err, 1);
      chk("tmo_crc_err", crc_err, 0);
      chk("tmo_err_addr", err_addr, a);
      chk("tmo_err_cnt", err_cnt, 1);
    end
    sb_addr.push_back(7'h04);
    serve(2, 1, 8'h42, 1'b0, 1'b0, mkres(0, 1, 7'h03, 8'd1, 1));

    // Enable drops while a request is outstanding.
    sb_addr.push_back(7'h03);
    wait_req(w, seen);
    if (!seen) begin
      fail_now("endrop_rd_req_wait");
    end else begin
      chk("endrop_req_latency", w, 3);
      a = sb_addr.pop_front();
      chk("endrop_rd_addr", raddr, a);
      @(posedge clk);
      #1 en = 1'b0;
      hi = 0;
      repeat (10) begin
        @(negedge clk);
        if (rd_req) hi++;
      end
      chk("endrop_req_hold", hi, 10);
      ack_and_check(a, 1, 8'h99, 1'b0, 1'b0, mkres(0, 1, 7'h03, 8'd1, 0));
      anyreq = 0;
      repeat (20) begin
        @(negedge clk);
        if (rd_req) anyreq++;
      end
      chk("endrop_no_more_req", anyreq, 0);
    end

    // Clear coinciding with a new mismatch at 0x05.
    sa = 7'h05; ea = 7'h05; intv = 16'd0;
    sb_addr.push_back(7'h05);
    @(posedge clk);
    #1 en = 1'b1;
    serve(3, 2, 8'h12, 1'b1, 1'b1, mkres(1, 0, 7'h05, 8'd1, 1));
    en = 1'b0;
    clear_errs();

    // Inverted window: every read at 0x10, done every read, counter saturates.
    sa = 7'h10; ea = 7'h08; intv = 16'd0;
    @(posedge clk);
    #1 en = 1'b1;
    for (int i = 0; i < 257; i++) begin
      n = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
      sb_addr.push_back(7'h10);
      serve((i == 0) ? 3 : 1, 1, 8'(i), 1'b1, 1'b0, mkres(1, 0, 7'h10, n, 1));
    end
    en = 1'b0;

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
